// File: rtl/sincap_pkg.sv
// sincap_pkg: shared FSM states, default widths and tagged word layout for the sincap receiver
package sincap_pkg;
    localparam int DW_DEF = 12;
    localparam int LW_DEF = 12;
    typedef enum logic [1:0] {IDLE, FRAME, LINE} state_t;
    typedef struct packed {
        logic sof;
        logic eol;
        logic [DW_DEF-1:0] data;
    } word_t;
endpackage

// File: rtl/sincap_fifo.sv
// sincap_fifo: synchronous first-word-fall-through FIFO; a push on full is accepted only alongside a pop
module sincap_fifo #(
    parameter int W = 14,
    parameter int DEPTH = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr_en,
    input  logic [W-1:0] wr_data,
    input  logic         rd_en,
    output logic [W-1:0] rd_data,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0] mem [DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic [AW:0] cnt;
    logic wr, rd;
    assign full = cnt == (AW+1)'(DEPTH);
    assign empty = cnt == '0;
    assign rd = rd_en & ~empty;
    assign wr = wr_en & (~full | rd);
    assign rd_data = mem[rptr];
    // pointer and occupancy tracking
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
            cnt <= '0;
        end else begin
            wptr <= wr ? wptr + 1'b1 : wptr;
            rptr <= rd ? rptr + 1'b1 : rptr;
            cnt <= cnt + (AW+1)'(wr) - (AW+1)'(rd);
        end
    end
    // storage array, no reset needed since empty masks stale contents
    always_ff @(posedge clk) begin
        if (wr) mem[wptr] <= wr_data;
    end
endmodule

// File: rtl/sincap_rx.sv
// sincap_rx: parallel sample receiver with frame/line decode, eol lookahead and FWFT stream output; SINCAP_PEAK_DETECT_EN adds peak_max/peak_min
module sincap_rx
    import sincap_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int FIFO_DEPTH = 16,
    parameter int LW = LW_DEF
) (
    input  logic          clkin,
    input  logic          rst,
    input  logic [DW-1:0] sin_x,
    input  logic          vsync,
    input  logic          hsync,
    output logic [DW-1:0] m_data,
    output logic          m_sof,
    output logic          m_eol,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [LW-1:0] line_len,
    output logic [LW-1:0] line_cnt,
    output logic [15:0]   frame_cnt,
    output logic          frame_done,
    output logic          overflow
`ifdef SINCAP_PEAK_DETECT_EN
    ,
    output logic [DW-1:0] peak_max,
    output logic [DW-1:0] peak_min
`endif
);
    state_t state, state_nx;
    logic [DW-1:0] s_x, hold_x;
    logic s_vsync, s_hsync, p_vsync, p_hsync, hold_v, sof_pend;
    logic vs_rise, vs_fall, hs_fall, frame_start, capture, line_end, frame_end, push, pop, full, empty;
    logic [LW-1:0] samp_cnt, lines, lines_nx;
    assign vs_rise = s_vsync & ~p_vsync;
    assign vs_fall = ~s_vsync & p_vsync;
    assign hs_fall = ~s_hsync & p_hsync;
    assign frame_start = (state == IDLE) & vs_rise;
    assign push = (capture | line_end) & hold_v;
    assign m_valid = ~empty;
    assign pop = m_valid & m_ready;
    assign lines_nx = (line_end && lines != '1) ? lines + 1'b1 : lines;
    // input registers; vsync history resets high so a frame already running at reset release is not seen as a new one
    always_ff @(posedge clkin) begin
        if (rst) begin
            s_x <= '0;
            s_vsync <= 1'b1;
            s_hsync <= 1'b0;
            p_vsync <= 1'b1;
            p_hsync <= 1'b0;
        end else begin
            s_x <= sin_x;
            s_vsync <= vsync;
            s_hsync <= hsync;
            p_vsync <= s_vsync;
            p_hsync <= s_hsync;
        end
    end
    // framing state register
    always_ff @(posedge clkin) begin
        if (rst) state <= IDLE;
        else state <= state_nx;
    end
    // framing decode: capture, line end and frame end strobes
    always_comb begin
        state_nx = state;
        capture = 1'b0;
        line_end = 1'b0;
        frame_end = 1'b0;
        case (state)
            IDLE: state_nx = vs_rise ? FRAME : IDLE;
            FRAME: begin
                frame_end = vs_fall;
                capture = ~vs_fall & s_hsync & s_vsync;
                state_nx = vs_fall ? IDLE : (capture ? LINE : FRAME);
            end
            LINE: begin
                frame_end = vs_fall;
                line_end = vs_fall | hs_fall;
                capture = ~line_end & s_hsync;
                state_nx = vs_fall ? IDLE : (hs_fall ? FRAME : LINE);
            end
            default: state_nx = IDLE;
        endcase
    end
    // hold register, sof tagging, counters and status
    always_ff @(posedge clkin) begin
        if (rst) begin
            hold_v <= 1'b0;
            hold_x <= '0;
            sof_pend <= 1'b0;
            samp_cnt <= '0;
            lines <= '0;
            line_len <= '0;
            line_cnt <= '0;
            frame_cnt <= '0;
            frame_done <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (capture) begin
                hold_x <= s_x;
                hold_v <= 1'b1;
                samp_cnt <= (state == FRAME) ? LW'(1) : (samp_cnt == '1 ? samp_cnt : samp_cnt + 1'b1);
            end else if (line_end) begin
                hold_v <= 1'b0;
            end
            sof_pend <= frame_start ? 1'b1 : (push ? 1'b0 : sof_pend);
            lines <= frame_start ? '0 : lines_nx;
            if (line_end) line_len <= samp_cnt;
            frame_done <= frame_end;
            if (frame_end) begin
                frame_cnt <= frame_cnt + 1'b1;
                line_cnt <= lines_nx;
            end
            if (push && full && !pop) overflow <= 1'b1;
        end
    end
    sincap_fifo #(.W(DW + 2), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk(clkin),
        .rst(rst),
        .wr_en(push),
        .wr_data({sof_pend, line_end, hold_x}),
        .rd_en(m_ready),
        .rd_data({m_sof, m_eol, m_data}),
        .full(full),
        .empty(empty)
    );
`ifdef SINCAP_PEAK_DETECT_EN
    logic [DW-1:0] run_max, run_min;
    // running extremes over the current frame, published at frame end
    always_ff @(posedge clkin) begin
        if (rst) begin
            run_max <= '0;
            run_min <= '1;
            peak_max <= '0;
            peak_min <= '0;
        end else begin
            if (frame_start) begin
                run_max <= '0;
                run_min <= '1;
            end else if (capture) begin
                run_max <= (s_x > run_max) ? s_x : run_max;
                run_min <= (s_x < run_min) ? s_x : run_min;
            end
            if (frame_end) begin
                peak_max <= run_max;
                peak_min <= run_min;
            end
        end
    end
`endif
endmodule

// File: tb/tb_sincap_rx.sv
// tb_sincap_rx: scoreboard bench for sincap_rx; directed frames, monitor pops expected words on each transfer
module tb_sincap_rx;
    logic clkin, rst, vsync, hsync, m_ready;
    logic [11:0] sin_x, m_data;
    logic m_sof, m_eol, m_valid, frame_done, overflow;
    logic [11:0] line_len, line_cnt;
    logic [15:0] frame_cnt;
`ifdef SINCAP_PEAK_DETECT_EN
    logic [11:0] peak_max, peak_min;
`endif
    int vectors = 0;
    int miscompares = 0;
    int fd_cnt = 0;
    logic [13:0] q[$];
    logic stall_v = 1'b0;
    logic [13:0] stall_w = '0;

    sincap_rx #(.DW(12), .FIFO_DEPTH(16), .LW(12)) dut (
        .clkin(clkin), .rst(rst), .sin_x(sin_x), .vsync(vsync), .hsync(hsync),
        .m_data(m_data), .m_sof(m_sof), .m_eol(m_eol), .m_valid(m_valid), .m_ready(m_ready),
        .line_len(line_len), .line_cnt(line_cnt), .frame_cnt(frame_cnt),
        .frame_done(frame_done), .overflow(overflow)
`ifdef SINCAP_PEAK_DETECT_EN
        , .peak_max(peak_max), .peak_min(peak_min)
`endif
    );

    initial clkin = 1'b0;
    always #5 clkin = ~clkin;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clkin);
        #1;
    endtask

    // monitor: compare every transferred word against the scoreboard, and held words during stalls
    always @(negedge clkin) begin
        logic [13:0] w;
        if (rst) begin
            stall_v = 1'b0;
        end else begin
            if (frame_done) fd_cnt++;
            if (stall_v && m_valid) chk("stall_hold", {18'd0, m_sof, m_eol, m_data}, {18'd0, stall_w});
            stall_v = m_valid && !m_ready;
            stall_w = {m_sof, m_eol, m_data};
            if (m_valid && m_ready) begin
                if (q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_word: got %0h expected none", {m_sof, m_eol, m_data});
                end else begin
                    w = q.pop_front();
                    chk("word", {18'd0, m_sof, m_eol, m_data}, {18'd0, w});
                end
                if (m_data == 12'hABC && m_eol) chk("abc_frame_done", {31'd0, frame_done}, 32'd1);
            end
        end
    end

    task automatic send_frame(input int nl, input int ll, input logic [11:0] base, input int max_exp);
        int idx;
        logic [11:0] v;
        idx = 0;
        vsync = 1'b1;
        repeat (2) tick;
        for (int l = 0; l < nl; l++) begin
            for (int s = 0; s < ll; s++) begin
                v = base + 12'(l * ll + s);
                hsync = 1'b1;
                sin_x = v;
                if (idx < max_exp) q.push_back({idx == 0, s == ll - 1, v});
                idx++;
                tick;
            end
            hsync = 1'b0;
            sin_x = '0;
            repeat (2) tick;
        end
        vsync = 1'b0;
        repeat (3) tick;
    endtask

    task automatic frame3(input logic [11:0] a, input logic [11:0] b, input logic [11:0] c, input bit tight);
        logic [11:0] v[3];
        v = '{a, b, c};
        vsync = 1'b1;
        repeat (2) tick;
        for (int i = 0; i < 3; i++) begin
            hsync = 1'b1;
            sin_x = v[i];
            q.push_back({i == 0, i == 2, v[i]});
            tick;
        end
        hsync = 1'b0;
        if (!tight) repeat (2) tick;
        vsync = 1'b0;
        repeat (4) tick;
    endtask

    task automatic drain;
        int n;
        n = 0;
        while ((q.size() != 0 || m_valid) && n < 100) begin
            tick;
            n++;
        end
        chk("drain_left", q.size(), 0);
    endtask

    initial begin
        rst = 1'b1;
        vsync = 1'b0;
        hsync = 1'b0;
        sin_x = '0;
        m_ready = 1'b1;
        repeat (3) tick;
        rst = 1'b0;
        tick;
        chk("rst_m_valid", {31'd0, m_valid}, 0);
        chk("rst_line_len", {20'd0, line_len}, 0);
        chk("rst_line_cnt", {20'd0, line_cnt}, 0);
        chk("rst_frame_cnt", {16'd0, frame_cnt}, 0);
        chk("rst_frame_done", {31'd0, frame_done}, 0);
        chk("rst_overflow", {31'd0, overflow}, 0);
        fd_cnt = 0;
        send_frame(3, 5, 12'h000, 100);
        drain;
        chk("f1_line_len", {20'd0, line_len}, 5);
        chk("f1_line_cnt", {20'd0, line_cnt}, 3);
        chk("f1_frame_cnt", {16'd0, frame_cnt}, 1);
        chk("f1_done_pulses", fd_cnt, 1);
        vsync = 1'b1;
        repeat (2) tick;
        rst = 1'b1;
        repeat (2) tick;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            hsync = 1'b1;
            sin_x = 12'h1F0 + 12'(i);
            tick;
        end
        hsync = 1'b0;
        repeat (2) tick;
        vsync = 1'b0;
        repeat (3) tick;
        chk("midrst_frame_cnt", {16'd0, frame_cnt}, 0);
        chk("midrst_m_valid", {31'd0, m_valid}, 0);
        send_frame(2, 3, 12'h100, 100);
        drain;
        chk("f2_line_len", {20'd0, line_len}, 3);
        chk("f2_line_cnt", {20'd0, line_cnt}, 2);
        chk("f2_frame_cnt", {16'd0, frame_cnt}, 1);
        m_ready = 1'b0;
        send_frame(1, 20, 12'h200, 16);
        chk("ovf_flag", {31'd0, overflow}, 1);
        chk("ovf_m_valid", {31'd0, m_valid}, 1);
        chk("ovf_line_len", {20'd0, line_len}, 20);
        m_ready = 1'b1;
        drain;
        chk("ovf_frame_cnt", {16'd0, frame_cnt}, 2);
        frame3(12'h0AA, 12'h0BB, 12'hABC, 1'b1);
        drain;
        chk("tight_line_len", {20'd0, line_len}, 3);
        chk("tight_line_cnt", {20'd0, line_cnt}, 1);
        chk("tight_frame_cnt", {16'd0, frame_cnt}, 3);
        send_frame(4, 1, 12'h301, 100);
        drain;
        chk("single_line_len", {20'd0, line_len}, 1);
        chk("single_line_cnt", {20'd0, line_cnt}, 4);
        chk("single_frame_cnt", {16'd0, frame_cnt}, 4);
`ifdef SINCAP_PEAK_DETECT_EN
        frame3(12'h800, 12'hFFF, 12'h001, 1'b0);
        drain;
        chk("peak_max", {20'd0, peak_max}, 32'hFFF);
        chk("peak_min", {20'd0, peak_min}, 32'h001);
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
